// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Brief    : Shared op codes, latch widths and FSM encoding for the MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

   localparam int DBITS_DEF     = 32;
   localparam int REGNOBITS_DEF = 5;
   localparam int INSTBITS_DEF  = 32;
   localparam int IOPBITS       = 5;

   localparam int MEM_latch_WIDTH       = INSTBITS_DEF + DBITS_DEF + IOPBITS + DBITS_DEF + REGNOBITS_DEF + 1;
   localparam int from_MEM_to_AGEX_WIDTH = 1 + REGNOBITS_DEF + DBITS_DEF;
   localparam int from_MEM_to_DE_WIDTH   = 1 + REGNOBITS_DEF;

   // Non-memory ops occupy the low codes; memory ops live in 16..23.
   localparam logic [IOPBITS-1:0] NOP_I  = 5'd0;
   localparam logic [IOPBITS-1:0] ADD_I  = 5'd1;
   localparam logic [IOPBITS-1:0] SUB_I  = 5'd2;
   localparam logic [IOPBITS-1:0] AND_I  = 5'd3;
   localparam logic [IOPBITS-1:0] OR_I   = 5'd4;
   localparam logic [IOPBITS-1:0] LB_I   = 5'd16;
   localparam logic [IOPBITS-1:0] LH_I   = 5'd17;
   localparam logic [IOPBITS-1:0] LW_I   = 5'd18;
   localparam logic [IOPBITS-1:0] LBU_I  = 5'd19;
   localparam logic [IOPBITS-1:0] LHU_I  = 5'd20;
   localparam logic [IOPBITS-1:0] SB_I   = 5'd21;
   localparam logic [IOPBITS-1:0] SH_I   = 5'd22;
   localparam logic [IOPBITS-1:0] SW_I   = 5'd23;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_WAIT_RD = 2'd2;

   function automatic logic is_load(input logic [IOPBITS-1:0] op);
      return (op == LB_I) || (op == LH_I) || (op == LW_I) || (op == LBU_I) || (op == LHU_I);
   endfunction

   function automatic logic is_store(input logic [IOPBITS-1:0] op);
      return (op == SB_I) || (op == SH_I) || (op == SW_I);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Brief    : Selects and sign/zero-extends the addressed lane of a load word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_align
   import mem_stage_pkg::*;
#(
   parameter int DBITS = 32
) (
   input  logic [DBITS-1:0]   rdata,
   input  logic [1:0]         offset,
   input  logic [IOPBITS-1:0] op,
   output logic [DBITS-1:0]   ldval
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (offset)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
      w_half = offset[1] ? rdata[31:16] : rdata[15:0];

      case (op)
         LB_I:    ldval = {{(DBITS-8){w_byte[7]}}, w_byte};
         LBU_I:   ldval = {{(DBITS-8){1'b0}}, w_byte};
         LH_I:    ldval = {{(DBITS-16){w_half[15]}}, w_half};
         LHU_I:   ldval = {{(DBITS-16){1'b0}}, w_half};
         default: ldval = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : MEM pipeline stage: req/gnt/rvalid data port, RV32I sub-word
//            formatting, upstream stall and MEM latch. Optional macro
//            MEM_MISALIGN_CHK_EN adds misaligned-access suppression and a
//            sticky misalign_err output.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DBITS     = 32,
   parameter int REGNOBITS = 5,
   parameter int INSTBITS  = 32
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       in_valid,
   input  logic [INSTBITS-1:0]                        in_inst,
   input  logic [DBITS-1:0]                           in_pc,
   input  logic [IOPBITS-1:0]                         in_op,
   input  logic [DBITS-1:0]                           in_aluout,
   input  logic [DBITS-1:0]                           in_stdata,
   input  logic [REGNOBITS-1:0]                       in_rd,
   input  logic                                       in_wr_reg,
   output logic                                       mem_stall,
   output logic                                       dmem_req,
   output logic                                       dmem_we,
   output logic [DBITS-1:0]                           dmem_addr,
   output logic [3:0]                                 dmem_be,
   output logic [DBITS-1:0]                           dmem_wdata,
   input  logic                                       dmem_gnt,
   input  logic                                       dmem_rvalid,
   input  logic [DBITS-1:0]                           dmem_rdata,
`ifdef MEM_MISALIGN_CHK_EN
   output logic                                       misalign_err,
`endif
   output logic [INSTBITS+2*DBITS+IOPBITS+REGNOBITS:0] MEM_latch_out,
   output logic [REGNOBITS+DBITS:0]                   from_MEM_to_AGEX,
   output logic [REGNOBITS:0]                         from_MEM_to_DE
);

   localparam int LATCH_W = INSTBITS + 2*DBITS + IOPBITS + REGNOBITS + 1;

   logic [1:0]         r_state;
   logic [1:0]         w_state_d;
   logic [1:0]         w_cur;
   logic [LATCH_W-1:0] r_latch;
   logic [LATCH_W-1:0] w_latch_d;
   logic [1:0]         w_off;
   logic               w_is_ld;
   logic               w_is_st;
   logic               w_misalign;
   logic               w_mem;
   logic               w_req;
   logic               w_complete;
   logic [DBITS-1:0]   w_ldval;
   logic [DBITS-1:0]   w_wbval;
   logic               w_wr;

   assign w_off   = in_aluout[1:0];
   assign w_is_ld = is_load(in_op);
   assign w_is_st = is_store(in_op);

`ifdef MEM_MISALIGN_CHK_EN
   logic r_misalign_err;

   assign w_misalign = in_valid &&
                       ((((in_op == LH_I) || (in_op == LHU_I) || (in_op == SH_I)) && w_off[0]) ||
                        (((in_op == LW_I) || (in_op == SW_I)) && (w_off != 2'd0)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_misalign_err <= 1'b0;
      else if (w_misalign)
         r_misalign_err <= 1'b1;
   end

   assign misalign_err = r_misalign_err;
`else
   assign w_misalign = 1'b0;
`endif

   assign w_mem = in_valid && (w_is_ld || w_is_st) && !w_misalign;

   // IDLE with a live memory op behaves as REQ in the same cycle.
   always_comb begin
      w_cur = r_state;
      if ((r_state == ST_IDLE) && w_mem)
         w_cur = ST_REQ;
      w_req      = w_mem && (w_cur == ST_REQ);
      w_complete = (w_is_st && w_req && dmem_gnt) ||
                   (w_mem && (r_state == ST_WAIT_RD) && dmem_rvalid);

      w_state_d = ST_IDLE;
      case (w_cur)
         ST_REQ: begin
            if (!w_mem)
               w_state_d = ST_IDLE;
            else if (dmem_gnt)
               w_state_d = w_is_ld ? ST_WAIT_RD : ST_IDLE;
            else
               w_state_d = ST_REQ;
         end
         ST_WAIT_RD: begin
            if (!w_mem || dmem_rvalid)
               w_state_d = ST_IDLE;
            else
               w_state_d = ST_WAIT_RD;
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_d;
   end

   mem_load_align #(
      .DBITS (DBITS)
   ) u_load_align (
      .rdata  (dmem_rdata),
      .offset (w_off),
      .op     (in_op),
      .ldval  (w_ldval)
   );

   always_comb begin
      w_wbval   = w_is_ld ? w_ldval : in_aluout;
      w_wr      = w_is_st ? 1'b0 : in_wr_reg;
      w_latch_d = '0;
      if (in_valid && !w_misalign && (!(w_is_ld || w_is_st) || w_complete))
         w_latch_d = {in_inst, in_pc, in_op, w_wbval, in_rd, w_wr};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_latch <= '0;
      else
         r_latch <= w_latch_d;
   end

   // Store lane steering; bits above the lane are replicated copies.
   always_comb begin
      dmem_be    = 4'b1111;
      dmem_wdata = in_stdata;
      case (in_op)
         SB_I: begin
            dmem_be    = 4'b0001 << w_off;
            dmem_wdata = {(DBITS/8){in_stdata[7:0]}};
         end
         SH_I: begin
            dmem_be    = 4'b0011 << {w_off[1], 1'b0};
            dmem_wdata = {(DBITS/16){in_stdata[15:0]}};
         end
         default: begin
            dmem_be    = 4'b1111;
            dmem_wdata = in_stdata;
         end
      endcase
   end

   assign dmem_addr = {in_aluout[DBITS-1:2], 2'b00};
   assign dmem_req  = reset && w_req;
   assign dmem_we   = reset && w_req && w_is_st;
   assign mem_stall = reset && w_mem && !w_complete;

   assign MEM_latch_out    = r_latch;
   assign from_MEM_to_AGEX = {r_latch[0], r_latch[REGNOBITS:1], r_latch[REGNOBITS+DBITS:REGNOBITS+1]};
   assign from_MEM_to_DE   = {r_latch[0], r_latch[REGNOBITS:1]};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [31:0]  in_inst;
   logic [31:0]  in_pc;
   logic [4:0]   in_op;
   logic [31:0]  in_aluout;
   logic [31:0]  in_stdata;
   logic [4:0]   in_rd;
   logic         in_wr_reg;
   logic         mem_stall;
   logic         dmem_req;
   logic         dmem_we;
   logic [31:0]  dmem_addr;
   logic [3:0]   dmem_be;
   logic [31:0]  dmem_wdata;
   logic         dmem_gnt;
   logic         dmem_rvalid;
   logic [31:0]  dmem_rdata;
   logic [106:0] MEM_latch_out;
   logic [37:0]  from_MEM_to_AGEX;
   logic [5:0]   from_MEM_to_DE;
`ifdef MEM_MISALIGN_CHK_EN
   logic         misalign_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage u_dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_inst          (in_inst),
      .in_pc            (in_pc),
      .in_op            (in_op),
      .in_aluout        (in_aluout),
      .in_stdata        (in_stdata),
      .in_rd            (in_rd),
      .in_wr_reg        (in_wr_reg),
      .mem_stall        (mem_stall),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_be          (dmem_be),
      .dmem_wdata       (dmem_wdata),
      .dmem_gnt         (dmem_gnt),
      .dmem_rvalid      (dmem_rvalid),
      .dmem_rdata       (dmem_rdata),
`ifdef MEM_MISALIGN_CHK_EN
      .misalign_err     (misalign_err),
`endif
      .MEM_latch_out    (MEM_latch_out),
      .from_MEM_to_AGEX (from_MEM_to_AGEX),
      .from_MEM_to_DE   (from_MEM_to_DE)
   );

   always #5 clk = ~clk;

   // Latch layout {inst, pc, op, wbval, rd, wr_reg}
   wire [31:0] lat_inst  = MEM_latch_out[106:75];
   wire [4:0]  lat_op    = MEM_latch_out[42:38];
   wire [31:0] lat_wbval = MEM_latch_out[37:6];
   wire [4:0]  lat_rd    = MEM_latch_out[5:1];
   wire        lat_wr    = MEM_latch_out[0];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] alu,
                        input logic [31:0] st, input logic [4:0] rd, input logic wr);
      in_valid  = v;
      in_inst   = v ? (32'hC0DE_0000 | {27'd0, op}) : 32'd0;
      in_pc     = v ? 32'h0000_1000 : 32'd0;
      in_op     = op;
      in_aluout = alu;
      in_stdata = st;
      in_rd     = rd;
      in_wr_reg = wr;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input string tag, input logic [4:0] op, input logic [31:0] addr,
                           input logic [31:0] st, input int nwait,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      int stalls = 0;
      drive(1'b1, op, addr, st, 5'd7, 1'b1);
      for (int i = 0; i <= nwait; i++) begin
         dmem_gnt = (i == nwait);
         @(negedge clk);
         check({tag, "_req"}, dmem_req, 1'b1);
         check({tag, "_we"}, dmem_we, 1'b1);
         check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
         check({tag, "_be"}, dmem_be, exp_be);
         check({tag, "_wdata"}, dmem_wdata, exp_wdata);
         if (i > 0) check({tag, "_bubble"}, MEM_latch_out, 107'd0);
         if (mem_stall) stalls++;
         next_cycle();
      end
      dmem_gnt = 1'b0;
      drive(1'b0, NOP_I, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      check({tag, "_stallcnt"}, stalls, nwait);
      check({tag, "_wr0"}, lat_wr, 1'b0);
      check({tag, "_op"}, lat_op, op);
      next_cycle();
   endtask

   task automatic do_load(input string tag, input logic [4:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
      drive(1'b1, op, addr, 32'd0, 5'd9, 1'b1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      check({tag, "_req"}, dmem_req, 1'b1);
      check({tag, "_we"}, dmem_we, 1'b0);
      check({tag, "_stall0"}, mem_stall, 1'b1);
      next_cycle();
      dmem_gnt = 1'b0;
      @(negedge clk);
      check({tag, "_reqwait"}, dmem_req, 1'b0);
      check({tag, "_stall1"}, mem_stall, 1'b1);
      next_cycle();
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(negedge clk);
      check({tag, "_stall2"}, mem_stall, 1'b0);
      next_cycle();
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
      drive(1'b0, NOP_I, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      check({tag, "_wbval"}, lat_wbval, exp);
      check({tag, "_rd"}, lat_rd, 5'd9);
      check({tag, "_wr"}, lat_wr, 1'b1);
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
      drive(1'b0, NOP_I, 32'd0, 32'd0, 5'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      drive(1'b1, LW_I, 32'h100, 32'd0, 5'd3, 1'b1);
      @(negedge clk);
      check("rst_latch", MEM_latch_out, 107'd0);
      check("rst_req", dmem_req, 1'b0);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_agex", from_MEM_to_AGEX, 38'd0);
      check("rst_de", from_MEM_to_DE, 6'd0);
      next_cycle();
      drive(1'b0, NOP_I, 32'd0, 32'd0, 5'd0, 1'b0);
      reset = 1'b1;
      next_cycle();

      // Non-memory op, one-cycle latency, then bubble
      drive(1'b1, ADD_I, 32'h0000_0042, 32'd0, 5'd5, 1'b1);
      @(negedge clk);
      check("add_stall", mem_stall, 1'b0);
      check("add_req", dmem_req, 1'b0);
      next_cycle();
      drive(1'b0, ADD_I, 32'h0000_0099, 32'd0, 5'd6, 1'b1);
      @(negedge clk);
      check("add_wbval", lat_wbval, 32'h42);
      check("add_rd", lat_rd, 5'd5);
      check("add_wr", lat_wr, 1'b1);
      check("add_inst", lat_inst, 32'hC0DE_0001);
      check("add_agex", from_MEM_to_AGEX, {1'b1, 5'd5, 32'h42});
      check("add_de", from_MEM_to_DE, {1'b1, 5'd5});
      next_cycle();
      @(negedge clk);
      check("bubble", MEM_latch_out, 107'd0);
      next_cycle();

      do_store("sb", SB_I, 32'h103, 32'h0000_00AB, 3, 4'b1000, 32'hABAB_ABAB);
      do_store("sh", SH_I, 32'h202, 32'h1234_CDEF, 1, 4'b1100, 32'hCDEF_CDEF);
      do_store("sw", SW_I, 32'h204, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);

      do_load("lb",  LB_I,  32'h102, 32'h0080_0000, 32'hFFFF_FF80);
      do_load("lbu", LBU_I, 32'h102, 32'h0080_0000, 32'h0000_0080);
      do_load("lb3", LB_I,  32'h103, 32'h8001_1234, 32'hFFFF_FF80);
      do_load("lbu1", LBU_I, 32'h101, 32'h8001_1234, 32'h0000_0012);
      do_load("lh",  LH_I,  32'h202, 32'h8001_1234, 32'hFFFF_8001);
      do_load("lhu", LHU_I, 32'h200, 32'h8001_1234, 32'h0000_1234);
      do_load("lw",  LW_I,  32'h200, 32'h8001_1234, 32'h8001_1234);

      // Reset while waiting for read data abandons the access
      drive(1'b1, LW_I, 32'h300, 32'd0, 5'd4, 1'b1);
      dmem_gnt = 1'b1;
      next_cycle();
      dmem_gnt = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      check("rwr_req", dmem_req, 1'b0);
      check("rwr_stall", mem_stall, 1'b0);
      check("rwr_latch", MEM_latch_out, 107'd0);
      next_cycle();
      reset       = 1'b1;
      drive(1'b0, NOP_I, 32'd0, 32'd0, 5'd0, 1'b0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rwr_ign_req", dmem_req, 1'b0);
      next_cycle();
      check("rwr_ign_latch", MEM_latch_out, 107'd0);
      drive(1'b1, LW_I, 32'h300, 32'd0, 5'd4, 1'b1);
      @(negedge clk);
      check("rwr_idle_req", dmem_req, 1'b1);
      check("rwr_idle_stall", mem_stall, 1'b1);
      next_cycle();
      dmem_rvalid = 1'b0;
      dmem_gnt    = 1'b1;
      @(negedge clk);
      check("rwr_reqrv_latch", MEM_latch_out, 107'd0);
      next_cycle();
      dmem_gnt = 1'b0;
      next_cycle();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1122_3344;
      next_cycle();
      dmem_rvalid = 1'b0;
      drive(1'b0, NOP_I, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      check("rwr_final_wbval", lat_wbval, 32'h1122_3344);
      next_cycle();

`ifdef MEM_MISALIGN_CHK_EN
      @(negedge clk);
      check("mis_err0", misalign_err, 1'b0);
      next_cycle();
      drive(1'b1, LW_I, 32'h101, 32'd0, 5'd2, 1'b1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      check("mis_req", dmem_req, 1'b0);
      check("mis_stall", mem_stall, 1'b0);
      next_cycle();
      dmem_gnt = 1'b0;
      drive(1'b1, ADD_I, 32'h7, 32'd0, 5'd1, 1'b1);
      @(negedge clk);
      check("mis_latch", MEM_latch_out, 107'd0);
      check("mis_err1", misalign_err, 1'b1);
      next_cycle();
      drive(1'b0, NOP_I, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      check("mis_add_wbval", lat_wbval, 32'h7);
      check("mis_err_sticky", misalign_err, 1'b1);
      next_cycle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
